// File: rtl/alu_types_pkg.sv
// ALU operation encodings shared by decode and execute.
// Exports alu_op_t, the 4-bit ALU operation select.
package alu_types_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRA  = 4'd1,
        ALU_SRL  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

endpackage

// File: rtl/rv32i_types_pkg.sv
// RV32I decode types: opcodes, immediate selects, RV32M funct3,
// the decoded-entry bundle and immediate / ALU-op helpers.
package rv32i_types_pkg;

    import alu_types_pkg::*;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_IMMED   = 7'b0010011;
    localparam logic [6:0] OP_REGREG  = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_MISCMEM = 7'b0001111;
    localparam logic [6:0] OP_ZERO    = 7'b0000000;

    localparam logic [31:0] HALT_INSTR = 32'h0000_006f;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_SB,
        IMM_UJ,
        IMM_U,
        IMM_SHAMT
    } imm_sel_t;

    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } m_funct3_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        alu_op_t     alu_op;
        logic        wen;
        logic        dren;
        logic        dwen;
        logic        branch;
        logic        jump;
        logic        muldiv;
        logic [2:0]  funct3;
        logic        illegal;
        logic        halt;
    } decoded_t;

    function automatic logic [31:0] gen_imm(
        input imm_sel_t    sel,
        input logic [31:0] i
    );
        logic [31:0] r;
        unique case (sel)
            IMM_I:     r = {{20{i[31]}}, i[31:20]};
            IMM_S:     r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_SB:    r = {{19{i[31]}}, i[31], i[7],
                            i[30:25], i[11:8], 1'b0};
            IMM_UJ:    r = {{11{i[31]}}, i[31], i[19:12],
                            i[20], i[30:21], 1'b0};
            IMM_U:     r = {i[31:12], 12'b0};
            IMM_SHAMT: r = {27'b0, i[24:20]};
            default:   r = '0;
        endcase
        return r;
    endfunction

    // b30 picks SUB only for register-register ops; ADDI has no SUB.
    function automatic alu_op_t alu_from_f3(
        input logic [2:0] f3,
        input logic       b30,
        input logic       regreg
    );
        alu_op_t r;
        unique case (f3)
            3'd0:    r = (regreg && b30) ? ALU_SUB : ALU_ADD;
            3'd1:    r = ALU_SLL;
            3'd2:    r = ALU_SLT;
            3'd3:    r = ALU_SLTU;
            3'd4:    r = ALU_XOR;
            3'd5:    r = b30 ? ALU_SRA : ALU_SRL;
            3'd6:    r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// instr_decoder: purely combinational RV32I(+M) decode of one word.
// Ports: instr (raw word) -> dec (decoded bundle, pc left zero).
module instr_decoder
    import alu_types_pkg::*;
    import rv32i_types_pkg::*;
#(
    parameter bit MEXT_EN      = 1'b0,
    parameter bit HALT_ON_LOOP = 1'b1
) (
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    imm_sel_t   sel;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        dec         = '0;
        sel         = IMM_NONE;
        dec.opcode  = op;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct3  = f3;
        dec.alu_op  = ALU_ADD;

        unique case (1'b1)
            (op == OP_LUI) || (op == OP_AUIPC): begin
                sel     = IMM_U;
                dec.wen = 1'b1;
            end
            (op == OP_JAL): begin
                sel      = IMM_UJ;
                dec.wen  = 1'b1;
                dec.jump = 1'b1;
            end
            (op == OP_JALR): begin
                sel      = IMM_I;
                dec.wen  = 1'b1;
                dec.jump = 1'b1;
            end
            (op == OP_BRANCH): begin
                sel        = IMM_SB;
                dec.branch = 1'b1;
            end
            (op == OP_LOAD): begin
                sel      = IMM_I;
                dec.wen  = 1'b1;
                dec.dren = 1'b1;
            end
            (op == OP_STORE): begin
                sel      = IMM_S;
                dec.dwen = 1'b1;
            end
            (op == OP_IMMED): begin
                sel = ((f3 == 3'd1) || (f3 == 3'd5))
                    ? IMM_SHAMT : IMM_I;
                dec.wen    = 1'b1;
                dec.alu_op = alu_from_f3(f3, instr[30], 1'b0);
            end
            (op == OP_REGREG): begin
                dec.alu_op = alu_from_f3(f3, instr[30], 1'b1);
                case (f7)
                    7'h00: dec.wen = 1'b1;
                    7'h20: begin
                        if ((f3 == 3'd0) || (f3 == 3'd5))
                            dec.wen = 1'b1;
                        else
                            dec.illegal = 1'b1;
                    end
                    7'h01: begin
                        if (MEXT_EN) begin
                            dec.wen    = 1'b1;
                            dec.muldiv = 1'b1;
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            (op == OP_SYSTEM): begin
                sel     = IMM_I;
                // ECALL/EBREAK-class (0) and funct3 4 do not write rd.
                dec.wen = (f3 != 3'd0) && (f3 != 3'd4);
            end
            (op == OP_MISCMEM) || (op == OP_ZERO): begin
            end
            default: dec.illegal = 1'b1;
        endcase

        dec.imm  = gen_imm(sel, instr);
        dec.halt = HALT_ON_LOOP && (instr == HALT_INSTR);
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes fetched words and queues DEPTH decoded entries.
// Ports: CLK/RST, flush, in_* push side, out_* head side, count.
module decode_stage
    import alu_types_pkg::*;
    import rv32i_types_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter bit          MEXT_EN      = 1'b0,
    parameter bit          HALT_ON_LOOP = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [31:0]                out_imm,
    output alu_op_t                    out_alu_op,
    output logic                       out_wen,
    output logic                       out_dren,
    output logic                       out_dwen,
    output logic                       out_branch,
    output logic                       out_jump,
    output logic                       out_muldiv,
    output logic [2:0]                 out_funct3,
    output logic                       out_illegal,
    output logic                       out_halt,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    decoded_t        dec;
    decoded_t        wr_entry;
    decoded_t        head;
    decoded_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            halted;
    logic            live;
    logic            push;
    logic            pop;

    instr_decoder #(
        .MEXT_EN      (MEXT_EN),
        .HALT_ON_LOOP (HALT_ON_LOOP)
    ) u_dec (
        .instr (in_instr),
        .dec   (dec)
    );

    // live stays low through reset and the first edge after it,
    // so in_ready is held off while RST is asserted.
    assign in_ready  = live && !halted && (count < CW'(DEPTH));
    assign out_valid = (count != '0);

    // flush wins over any handshake in the same cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        wr_entry    = dec;
        wr_entry.pc = in_pc;
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            halted <= 1'b0;
            live   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                halted <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push && dec.halt)
                    halted <= 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Stale slots are never exposed: data reads as zero when empty.
    assign head = out_valid ? mem[rd_ptr] : '0;

    assign out_pc      = head.pc;
    assign out_opcode  = head.opcode;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_imm     = head.imm;
    assign out_alu_op  = head.alu_op;
    assign out_wen     = head.wen;
    assign out_dren    = head.dren;
    assign out_dwen    = head.dwen;
    assign out_branch  = head.branch;
    assign out_jump    = head.jump;
    assign out_muldiv  = head.muldiv;
    assign out_funct3  = head.funct3;
    assign out_illegal = head.illegal;
    assign out_halt    = head.halt;

endmodule
